// File: rtl/param_sp_ram.sv
// -----------------------------------------------------------------------------
// param_sp_ram
//   Parametrised single-port synchronous RAM with byte-enable writes,
//   configurable read latency (1 or 2), selectable read-during-write response
//   and a sequential clear engine started by reset or by a flush request.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset; restarts the clear engine
//   ena        in   access request
//   wea        in   1 = write, 0 = read (qualified by ena)
//   be         in   byte enables, bit i covers din[8i+7:8i]
//   din        in   write data
//   addr       in   word address
//   flush      in   request to zero the whole array (honoured in IDLE only)
//   dout       out  registered read data; holds between responses
//   read_valid out  one-cycle pulse when dout carries a new response
//   busy       out  clear engine active; requests are ignored
// -----------------------------------------------------------------------------
module param_sp_ram #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1,
  parameter int WR_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                wea,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   din,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                flush,
  output logic [DATA_W-1:0]   dout,
  output logic                read_valid,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  // Array index width; addresses above the array are caught by the range
  // check before the truncated index is ever used.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = rst | (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept, rd_req, wr_req, clr_we, in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] old_word, merged, resp_d;
  logic              resp_v;

  // flush wins over a same-cycle request; the request is simply dropped.
  assign accept   = ~rst & (state_q == ST_IDLE) & ~flush & ena;
  assign rd_req   = accept & ~wea;
  assign wr_req   = accept & wea;
  assign clr_we   = ~rst & (state_q == ST_CLEAR);
  assign in_range = {1'b0, addr} < DEPTH_X;
  assign idx      = addr[IDX_W-1:0];
  assign old_word = in_range ? mem[idx] : '0;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Writes only produce a response in write-first / read-first modes.
  assign resp_v = rd_req | (wr_req & (WR_MODE != 0));

  always_comb begin
    resp_d = old_word;
    if (wr_req && WR_MODE == 1) resp_d = in_range ? merged : '0;
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array itself has no reset branch; it is zeroed by the clear
  // engine one word per cycle so it can still map onto RAM macros.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= '0;
    end else if (wr_req && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline; flushed only by rst so reads issued before a flush
  // still deliver their pre-clear data. Data registers update only with a
  // valid response, so dout holds across idle and busy cycles.
  // ---------------------------------------------------------------------------
  logic              s1_v_q;
  logic [DATA_W-1:0] s1_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '1;
    end else begin
      s1_v_q <= resp_v;
      if (resp_v) s1_d_q <= resp_d;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s2_v_q;
      logic [DATA_W-1:0] s2_d_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_v_q <= 1'b0;
          s2_d_q <= '1;
        end else begin
          s2_v_q <= s1_v_q;
          if (s1_v_q) s2_d_q <= s1_d_q;
        end
      end

      assign dout       = s2_d_q;
      assign read_valid = s2_v_q;
    end else begin : g_lat1
      assign dout       = s1_d_q;
      assign read_valid = s1_v_q;
    end
  endgenerate

endmodule
